// File: rtl/tb_mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_ctrl: FIFO-buffered load/store sequencer for a memory with |
// | one-cycle synchronous reads. Optional: TB_MEM_ACC_CTRL_MISALIGN_TRAP_EN. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_access_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_sz,
  input  logic        req_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_sz,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        sz;
    logic        we;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  fifo_entry_t        r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_mem_sz;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic [15:0] r_txn_count;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_capture;
  logic        w_done;
  logic        w_trap;
  fifo_entry_t w_head;

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign w_head    = r_fifo[r_rd_ptr];

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_sz    = r_mem_sz;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign txn_count = r_txn_count;
  assign busy      = !w_empty || (r_state != S_IDLE);

  // ---------------- request FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {req_addr, req_wdata, req_sz, req_we};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- misalignment trap ----------------
`ifdef TB_MEM_ACC_CTRL_MISALIGN_TRAP_EN
  logic r_rsp_err;

  assign w_trap  = w_head.sz && w_head.addr[0];
  assign rsp_err = r_rsp_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_err <= 1'b0;
    end else if (w_pop) begin
      r_rsp_err <= w_trap;
    end else if (w_done) begin
      r_rsp_err <= 1'b0;
    end
  end
`else
  assign w_trap  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // mem_we is decoded from the state register so an asynchronous reset drops it at once
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_done       = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = w_trap ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_we       = r_we;
        w_next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture    = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------- issue and response datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_sz    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_txn_count <= '0;
    end else begin
      if (w_pop) begin
        if (w_trap) begin
          r_rsp_rdata <= '0;
          r_rsp_valid <= 1'b1;
        end else begin
          r_we        <= w_head.we;
          r_mem_addr  <= w_head.addr;
          r_mem_wdata <= w_head.wdata;
          r_mem_sz    <= w_head.sz;
        end
      end
      if (w_capture) begin
        r_rsp_rdata <= r_we ? 16'h0000 : mem_rdata;
        r_rsp_valid <= 1'b1;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b0;
        r_txn_count <= r_txn_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
